// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default sizes for the two-port RAM arbiter.
package mem_arbiter_pkg;
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;
  localparam int NPORTS = 2;
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } gnt_e;
endpackage

// File: rtl/mem_arb_rdret.sv
// Per-port load return register: one-cycle rvalid pulse, rdata held between loads.
module mem_arb_rdret #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] rdata_in,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= load;
      if (load) rdata_q <= rdata_in;
    end
  end

  // Outputs are forced quiet during reset so a load in flight never surfaces.
  assign rvalid = rvalid_q & ~reset;
  assign rdata  = reset ? '0 : rdata_q;
endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-RAM arbiter: A (pipeline) has priority over B (loader/debug).
// Define MEM_ARB_STARVE_EN to let B win after STARVE_LIMIT consecutive refusals.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_wen,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_wen,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_win,
  input  logic [DW-1:0] ram_rout,
  output logic [1:0]    last_grant
);
  logic gnt_a, gnt_b, b_force;
  gnt_e gnt_nxt, last_grant_q;

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign b_force = b_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts cycles B asks and is refused; any B grant or idle B clears it.
  always_ff @(posedge clock) begin
    if (reset || !b_req || gnt_b) starve_cnt <= '0;
    else if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign b_force = 1'b0;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (b_force)    gnt_b = 1'b1;
      else if (a_req) gnt_a = 1'b1;
      else if (b_req) gnt_b = 1'b1;
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_comb begin
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_win  = '0;
    if (gnt_a) begin
      ram_wen  = a_wen;
      ram_addr = a_addr;
      ram_win  = a_wdata;
    end else if (gnt_b) begin
      ram_wen  = b_wen;
      ram_addr = b_addr;
      ram_win  = b_wdata;
    end
  end

  always_comb begin
    gnt_nxt = GNT_NONE;
    if (gnt_a)      gnt_nxt = GNT_A;
    else if (gnt_b) gnt_nxt = GNT_B;
  end

  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= GNT_NONE;
    else       last_grant_q <= gnt_nxt;
  end

  assign last_grant = reset ? GNT_NONE : last_grant_q;

  logic [NPORTS-1:0]         ld_acc, rvalid;
  logic [NPORTS-1:0][DW-1:0] rdata;

  assign ld_acc[PORT_A] = gnt_a & ~a_wen;
  assign ld_acc[PORT_B] = gnt_b & ~b_wen;

  for (genvar p = 0; p < NPORTS; p++) begin : g_ret
    mem_arb_rdret #(.DW(DW)) u_ret (
      .clock    (clock),
      .reset    (reset),
      .load     (ld_acc[p]),
      .rdata_in (ram_rout),
      .rvalid   (rvalid[p]),
      .rdata    (rdata[p])
    );
  end

  assign a_rvalid = rvalid[PORT_A];
  assign a_rdata  = rdata[PORT_A];
  assign b_rvalid = rvalid[PORT_B];
  assign b_rdata  = rdata[PORT_B];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM (combinational read, posedge write).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_wen, b_req, b_wen;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready, a_rvalid, b_ready, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_win, ram_rout;
  logic [1:0]    last_grant;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clock = ~clock;

  assign ram_rout = mem[ram_addr];
  always @(posedge clock) if (ram_wen) mem[ram_addr] <= ram_win;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_win(ram_win), .ram_rout(ram_rout),
    .last_grant(last_grant)
  );

  task automatic drive_a(input logic req, input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_req = req; a_wen = wen; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_req = req; b_wen = wen; b_addr = addr; b_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_a(1'b1, 1'b0, 12'h010, '0);
    drive_b(1'b1, 1'b1, 12'h011, 16'h1111);
    repeat (2) next_cycle();
    @(negedge clock);
    tests++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin fails++;
      $display("FAIL reset_ready: a_ready=%b b_ready=%b expected 0 0", a_ready, b_ready); end
    tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin fails++;
      $display("FAIL reset_rvalid: a=%b b=%b expected 0 0", a_rvalid, b_rvalid); end
    tests++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin fails++;
      $display("FAIL reset_rdata: a=%h b=%h expected 0 0", a_rdata, b_rdata); end
    tests++; if (ram_wen !== 1'b0) begin fails++;
      $display("FAIL reset_ram_wen: got %b expected 0", ram_wen); end
    tests++; if (last_grant !== GNT_NONE) begin fails++;
      $display("FAIL reset_last_grant: got %0d expected 0", last_grant); end
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_a_only();
    drive_a(1'b1, 1'b0, 12'h010, '0);
    @(negedge clock);
    tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin fails++;
      $display("FAIL a_only_ready: a=%b b=%b expected 1 0", a_ready, b_ready); end
    tests++; if (ram_addr !== 12'h010 || ram_wen !== 1'b0) begin fails++;
      $display("FAIL a_only_ram: addr=%h wen=%b expected 010 0", ram_addr, ram_wen); end
    next_cycle();
    drive_a(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    tests++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin fails++;
      $display("FAIL a_only_rdata: rvalid=%b rdata=%h expected 1 1234", a_rvalid, a_rdata); end
    tests++; if (b_rvalid !== 1'b0) begin fails++;
      $display("FAIL a_only_b_rvalid: got %b expected 0", b_rvalid); end
    tests++; if (last_grant !== GNT_A) begin fails++;
      $display("FAIL a_only_last_grant: got %0d expected 1", last_grant); end
    next_cycle();
    @(negedge clock);
    tests++; if (a_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin fails++;
      $display("FAIL a_only_hold: rvalid=%b rdata=%h expected 0 1234", a_rvalid, a_rdata); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    drive_a(1'b1, 1'b1, 12'h020, 16'hBEEF);
    drive_b(1'b1, 1'b0, 12'h030, '0);
    @(negedge clock);
    tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin fails++;
      $display("FAIL sim_ready: a=%b b=%b expected 1 0", a_ready, b_ready); end
    tests++; if (ram_wen !== 1'b1 || ram_addr !== 12'h020 || ram_win !== 16'hBEEF) begin fails++;
      $display("FAIL sim_ram: wen=%b addr=%h win=%h expected 1 020 beef", ram_wen, ram_addr, ram_win); end
    next_cycle();
    drive_a(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    tests++; if (b_ready !== 1'b1 || a_rvalid !== 1'b0) begin fails++;
      $display("FAIL sim_b_accept: b_ready=%b a_rvalid=%b expected 1 0", b_ready, a_rvalid); end
    tests++; if (mem[12'h020] !== 16'hBEEF) begin fails++;
      $display("FAIL sim_store: mem[020]=%h expected beef", mem[12'h020]); end
    next_cycle();
    drive_b(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    tests++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h5A5A) begin fails++;
      $display("FAIL sim_b_rdata: rvalid=%b rdata=%h expected 1 5a5a", b_rvalid, b_rdata); end
    tests++; if (last_grant !== GNT_B) begin fails++;
      $display("FAIL sim_last_grant: got %0d expected 2", last_grant); end
    next_cycle();
  endtask

  task automatic test_write_read();
    drive_b(1'b1, 1'b1, 12'h005, 16'h00AA);
    @(negedge clock);
    tests++; if (b_ready !== 1'b1 || ram_wen !== 1'b1) begin fails++;
      $display("FAIL wr_store: b_ready=%b ram_wen=%b expected 1 1", b_ready, ram_wen); end
    next_cycle();
    drive_b(1'b1, 1'b0, 12'h005, '0);
    @(negedge clock);
    tests++; if (b_ready !== 1'b1 || b_rvalid !== 1'b0) begin fails++;
      $display("FAIL wr_load_accept: b_ready=%b b_rvalid=%b expected 1 0", b_ready, b_rvalid); end
    next_cycle();
    drive_b(1'b0, 1'b0, '0, '0);
    @(negedge clock);
    tests++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h00AA) begin fails++;
      $display("FAIL wr_rdata: rvalid=%b rdata=%h expected 1 00aa", b_rvalid, b_rdata); end
    next_cycle();
    @(negedge clock);
    tests++; if (b_rvalid !== 1'b0) begin fails++;
      $display("FAIL wr_single_pulse: b_rvalid=%b expected 0", b_rvalid); end
    next_cycle();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      tests++;
      if (ram_wen !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || a_rvalid !== 1'b0 ||
          b_rvalid !== 1'b0 || a_rdata !== 16'h1234 || b_rdata !== 16'h00AA) begin
        fails++;
        $display("FAIL idle_c%0d: wen=%b rdy=%b%b rv=%b%b rd=%h/%h expected 0 00 00 1234/00aa",
                 c, ram_wen, a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata);
      end
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    logic exp_b;
    drive_a(1'b1, 1'b0, 12'h010, '0);
    drive_b(1'b1, 1'b0, 12'h030, '0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
`ifdef MEM_ARB_STARVE_EN
      exp_b = (c == 5) || (c == 10);
`else
      exp_b = 1'b0;
`endif
      tests++;
      if (b_ready !== exp_b || a_ready !== !exp_b) begin
        fails++;
        $display("FAIL starve_c%0d: a_ready=%b b_ready=%b expected %b %b", c, a_ready, b_ready, !exp_b, exp_b);
      end
      next_cycle();
    end
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    next_cycle();
  endtask

  task automatic test_reset_mid_load();
    drive_a(1'b1, 1'b0, 12'h010, '0);
    @(negedge clock);
    tests++; if (a_ready !== 1'b1) begin fails++;
      $display("FAIL rml_accept: a_ready=%b expected 1", a_ready); end
    next_cycle();
    drive_a(1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    @(negedge clock);
    tests++; if (a_rvalid !== 1'b0 || a_rdata !== 16'h0 || last_grant !== GNT_NONE) begin fails++;
      $display("FAIL rml_during: rvalid=%b rdata=%h last_grant=%0d expected 0 0 0", a_rvalid, a_rdata, last_grant); end
    next_cycle();
`ifdef MEM_ARB_STARVE_EN
    tests++; if (dut.starve_cnt !== '0) begin fails++;
      $display("FAIL rml_counter: got %0d expected 0", dut.starve_cnt); end
`endif
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin fails++;
        $display("FAIL rml_after_c%0d: a_rvalid=%b b_rvalid=%b expected 0 0", c, a_rvalid, b_rvalid); end
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h010] = 16'h1234;
    mem[12'h030] = 16'h5A5A;
    reset = 1'b1;
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    test_reset();
    test_a_only();
    test_simultaneous();
    test_write_read();
    test_idle();
    test_starvation();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
